// File: rtl/gcd_client.sv
// gcd_client: hardware initiator for a GCD unit's val/rdy operand/result
// interface. A start pulse launches a run of num_reqs operations. Operand
// pairs begin at (base_a, base_b) and advance by (step_a, step_b) after each
// completed operation. Exactly one operation is in flight at a time, and the
// returned results are summed into a wrapping checksum.
//
// Optional build macro: GCD_CLIENT_STALL_EN
//   Adds result-side backpressure. result_rdy is asserted on at most one in
//   four WAIT cycles. Checksum and count results do not change.
//
// Parameters:
//   W      operand/result data width
//   CNT_W  width of the request count and the response counter
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start             begin a run (accepted only in IDLE or DONE)
//   num_reqs          operations in the run (sampled on accepted start)
//   base_a/base_b     first operand pair (sampled on accepted start)
//   step_a/step_b     per-operation operand increments (sampled on start)
//   busy / done       run in progress / run complete
//   checksum          sum of received results, mod 2^W
//   resp_count        results received in this run
//   operands_*        operand channel towards the GCD unit
//   result_*          result channel from the GCD unit
module gcd_client #(
    parameter int unsigned W     = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_reqs,
    input  logic [W-1:0]     base_a,
    input  logic [W-1:0]     base_b,
    input  logic [W-1:0]     step_a,
    input  logic [W-1:0]     step_b,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     checksum,
    output logic [CNT_W-1:0] resp_count,
    output logic [W-1:0]     operands_bits_A,
    output logic [W-1:0]     operands_bits_B,
    output logic             operands_val,
    input  logic             operands_rdy,
    input  logic [W-1:0]     result_bits_data,
    input  logic             result_val,
    output logic             result_rdy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     step_a_q;
    logic [W-1:0]     step_b_q;
    logic [CNT_W-1:0] target;
    logic [W-1:0]     checksum_q;
    logic [CNT_W-1:0] resp_count_q;
    logic [CNT_W-1:0] resp_next;
    logic             op_fire;
    logic             res_fire;

    assign resp_next = resp_count_q + CNT_W'(1);
    assign op_fire   = operands_val && operands_rdy;
    assign res_fire  = result_val && result_rdy;

    // All outputs derive from flops that reset asynchronously, so they read
    // zero as soon as reset is raised.
    assign busy            = (state == SEND) || (state == WAIT);
    assign done            = (state == DONE);
    assign operands_val    = (state == SEND);
    assign operands_bits_A = a_q;
    assign operands_bits_B = b_q;
    assign checksum        = checksum_q;
    assign resp_count      = resp_count_q;

`ifdef GCD_CLIENT_STALL_EN
    logic [3:0] stall_cnt;
    logic       unused_stall_hi;

    // The count restarts at each operand transfer, which is the entry into
    // WAIT. The first grant therefore falls on the fourth WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (op_fire) begin
            stall_cnt <= '0;
        end else if (state == WAIT) begin
            stall_cnt <= stall_cnt + 4'd1;
        end
    end

    assign result_rdy      = (state == WAIT) && (stall_cnt[1:0] == 2'b11);
    assign unused_stall_hi = ^stall_cnt[3:2];
`else
    assign result_rdy = (state == WAIT);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            step_a_q     <= '0;
            step_b_q     <= '0;
            target       <= '0;
            checksum_q   <= '0;
            resp_count_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q          <= base_a;
                        b_q          <= base_b;
                        step_a_q     <= step_a;
                        step_b_q     <= step_b;
                        target       <= num_reqs;
                        checksum_q   <= '0;
                        resp_count_q <= '0;
                        state        <= (num_reqs == '0) ? DONE : SEND;
                    end
                end
                SEND: begin
                    if (op_fire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (res_fire) begin
                        checksum_q   <= checksum_q + result_bits_data;
                        resp_count_q <= resp_next;
                        a_q          <= a_q + step_a_q;
                        b_q          <= b_q + step_b_q;
                        state        <= (resp_next == target) ? DONE : SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_client.sv
// Bench for gcd_client. A behavioural GCD unit answers operand requests.
// A run-level model predicts every output on every cycle: operand i is
// base + i*step, and the checksum is the sum of gcd() over the operands
// whose results have been delivered.
module tb_gcd_client;

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_reqs = '0;
    logic [W-1:0]     base_a = '0, base_b = '0, step_a = '0, step_b = '0;
    logic             busy, done, operands_val, result_rdy;
    logic [W-1:0]     checksum, operands_bits_A, operands_bits_B;
    logic [CNT_W-1:0] resp_count;
    logic             operands_rdy = 1'b0;
    logic [W-1:0]     result_bits_data = '0;
    logic             result_val = 1'b0;

    int checks = 0;
    int errors = 0;

    gcd_client #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_reqs(num_reqs),
        .base_a(base_a), .base_b(base_b), .step_a(step_a), .step_b(step_b),
        .busy(busy), .done(done), .checksum(checksum), .resp_count(resp_count),
        .operands_bits_A(operands_bits_A), .operands_bits_B(operands_bits_B),
        .operands_val(operands_val), .operands_rdy(operands_rdy),
        .result_bits_data(result_bits_data), .result_val(result_val),
        .result_rdy(result_rdy)
    );

    always #5 clk = ~clk;

    // Run model
    logic        m_run = 1'b0;
    int unsigned m_n = 0, m_cnt = 0, m_sent = 0, m_wait = 0;
    int unsigned m_ba = 0, m_bb = 0, m_sa = 0, m_sb = 0;
    logic [W-1:0] m_sum = '0;

    // Pre-edge snapshot
    logic             s_start = 1'b0, s_ofire = 1'b0, s_rfire = 1'b0;
    logic [CNT_W-1:0] s_num = '0;
    logic [W-1:0]     s_ba = '0, s_bb = '0, s_sa = '0, s_sb = '0, s_a = '0, s_b = '0;

    // Responder state
    logic         rsp_busy = 1'b0;
    logic [W-1:0] rsp_res = '0;
    int           rsp_delay = 0;
    int           lat = 2;
    int           ordy_block = 0;
    logic [2*W-1:0] op_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] ea(input int unsigned i);
        return W'(m_ba + i * m_sa);
    endfunction

    function automatic logic [W-1:0] eb(input int unsigned i);
        return W'(m_bb + i * m_sb);
    endfunction

    // Compare process, model update and GCD responder.
    initial begin : monitor
        logic busy_e, rrdy_e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_run = 1'b0; m_n = 0; m_cnt = 0; m_sent = 0; m_wait = 0; m_sum = '0;
                rsp_busy = 1'b0; result_val = 1'b0;
            end else begin
                if (s_rfire) begin
                    m_sum = m_sum + W'(gcd(32'(ea(m_cnt)), 32'(eb(m_cnt))));
                    m_cnt++;
                    result_val = 1'b0;
                    rsp_busy = 1'b0;
                end
                if (s_ofire) begin
                    op_q.push_back({s_a, s_b});
                    m_sent++;
                    m_wait = 0;
                    rsp_busy = 1'b1;
                    rsp_res = W'(gcd(32'(s_a), 32'(s_b)));
                    rsp_delay = lat;
                end
                if (s_start && !(m_run && m_cnt < m_n)) begin
                    m_run = 1'b1; m_n = 32'(s_num); m_cnt = 0; m_sent = 0; m_sum = '0;
                    m_ba = 32'(s_ba); m_bb = 32'(s_bb); m_sa = 32'(s_sa); m_sb = 32'(s_sb);
                end
            end

            busy_e = m_run && (m_cnt < m_n);
            rrdy_e = busy_e && (m_sent != m_cnt);
`ifdef GCD_CLIENT_STALL_EN
            rrdy_e = rrdy_e && (m_wait % 4 == 3);
`endif
            chk("busy", 32'(busy), 32'(busy_e));
            chk("done", 32'(done), 32'(m_run && m_cnt == m_n));
            chk("operands_val", 32'(operands_val), 32'(busy_e && m_sent == m_cnt));
            chk("result_rdy", 32'(result_rdy), 32'(rrdy_e));
            chk("checksum", 32'(checksum), 32'(m_sum));
            chk("resp_count", 32'(resp_count), 32'(CNT_W'(m_cnt)));
            chk("operand_A", 32'(operands_bits_A), m_run ? 32'(ea(m_cnt)) : 32'd0);
            chk("operand_B", 32'(operands_bits_B), m_run ? 32'(eb(m_cnt)) : 32'd0);
            if (m_sent != m_cnt) m_wait++;

            if (rsp_busy && !result_val) begin
                if (rsp_delay == 0) begin
                    result_val = 1'b1;
                    result_bits_data = rsp_res;
                end else begin
                    rsp_delay--;
                end
            end
            if (ordy_block > 0) begin
                operands_rdy = 1'b0;
                ordy_block--;
            end else begin
                operands_rdy = !rsp_busy;
            end

            @(negedge clk);
            #4;
            s_start = start; s_num = num_reqs;
            s_ba = base_a; s_bb = base_b; s_sa = step_a; s_sb = step_b;
            s_ofire = operands_val && operands_rdy;
            s_rfire = result_val && result_rdy;
            s_a = operands_bits_A; s_b = operands_bits_B;
        end
    end

    task automatic start_run(input int n, input int unsigned ba, input int unsigned bb,
                             input int unsigned sa, input int unsigned sb);
        @(negedge clk);
        start = 1'b1; num_reqs = CNT_W'(n);
        base_a = W'(ba); base_b = W'(bb); step_a = W'(sa); step_b = W'(sb);
        @(negedge clk);
        start = 1'b0;
        // Sampled inputs are free to move once the run has started.
        num_reqs = CNT_W'($urandom); base_a = W'($urandom); base_b = W'($urandom);
        step_a = W'($urandom); step_b = W'($urandom);
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", 32'(done), 32'd1);
    endtask

    initial begin : stimulus
        int qb;
        int k;
        logic [2*W-1:0] e;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single op
        start_run(1, 27, 15, 0, 0);
        chk("single_val", 32'(operands_val), 32'd1);
        chk("single_A", 32'(operands_bits_A), 32'd27);
        chk("single_B", 32'(operands_bits_B), 32'd15);
        wait_done(200);
        chk("single_sum", 32'(checksum), 32'd3);
        chk("single_cnt", 32'(resp_count), 32'd1);

        // Three-op sweep
        qb = op_q.size();
        start_run(3, 21, 49, 4, 0);
        wait_done(300);
        chk("sweep_sum", 32'(checksum), 32'd9);
        chk("sweep_cnt", 32'(resp_count), 32'd3);
        chk("sweep_nops", 32'(op_q.size() - qb), 32'd3);
        for (int i = 0; i < 3; i++) begin
            e = op_q[qb + i];
            chk("sweep_opA", 32'(e[2*W-1:W]), 32'(21 + 4 * i));
            chk("sweep_opB", 32'(e[W-1:0]), 32'd49);
        end

        // Operand backpressure
        qb = op_q.size();
        ordy_block = 7;
        start_run(1, 8, 12, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_val", 32'(operands_val), 32'd1);
            chk("bp_A", 32'(operands_bits_A), 32'd8);
            chk("bp_B", 32'(operands_bits_B), 32'd12);
            @(negedge clk);
        end
        wait_done(200);
        chk("bp_xfers", 32'(op_q.size() - qb), 32'd1);
        chk("bp_sum", 32'(checksum), 32'd4);

        // Start during a run is ignored
        start_run(2, 12, 18, 6, 0);
        @(negedge clk);
        start = 1'b1; num_reqs = 8'd1; base_a = 16'd100; base_b = 16'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        chk("ignore_sum", 32'(checksum), 32'd24);
        chk("ignore_cnt", 32'(resp_count), 32'd2);

        // Zero count
        start_run(0, 5, 5, 0, 0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_sum", 32'(checksum), 32'd0);
        chk("zero_cnt", 32'(resp_count), 32'd0);
        chk("zero_val", 32'(operands_val), 32'd0);

        // Operand wrap
        qb = op_q.size();
        start_run(2, 65535, 65535, 2, 0);
        wait_done(200);
        e = op_q[qb + 1];
        chk("wrap_opA", 32'(e[2*W-1:W]), 32'd1);
        chk("wrap_opB", 32'(e[W-1:0]), 32'd65535);
        chk("wrap_sum", 32'(checksum), 32'd0);

        // Checksum wrap: 2 * 40000 mod 65536
        start_run(2, 40000, 40000, 0, 0);
        wait_done(200);
        chk("csum_wrap", 32'(checksum), 32'd14464);

        // Maximum count
        lat = 0;
        start_run(255, 1, 2, 1, 1);
        wait_done(6000);
        chk("max_sum", 32'(checksum), 32'd255);
        chk("max_cnt", 32'(resp_count), 32'd255);

        // Reset in WAIT
        lat = 6;
        start_run(4, 30, 45, 1, 1);
        k = 0;
        while (!(busy && !operands_val) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reach_wait", 32'(busy && !operands_val), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_oval", 32'(operands_val), 32'd0);
        chk("rst_rrdy", 32'(result_rdy), 32'd0);
        chk("rst_sum", 32'(checksum), 32'd0);
        chk("rst_cnt", 32'(resp_count), 32'd0);
        chk("rst_A", 32'(operands_bits_A), 32'd0);
        chk("rst_B", 32'(operands_bits_B), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        lat = 2;
        start_run(1, 40, 40, 0, 0);
        wait_done(200);
        chk("post_rst_sum", 32'(checksum), 32'd40);
        chk("post_rst_cnt", 32'(resp_count), 32'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gcd_client.md
Name: gcd_client

Overview:
- Hardware initiator for the GCD unit's operands/result val/rdy interface: drives operand pairs and sinks results.
- Replaces the behavioural test source and sink when the GCD unit is exercised on silicon or FPGA without a bench.
- A host issues a start pulse with a request count and operand generation parameters.
- The block issues one operation at a time, accumulates a checksum of the returned results and reports completion.

Parameters:
- W, 16, operand/result data width.
- CNT_W, 8, width of request count and response counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; ignored unless in IDLE or DONE.
- num_reqs  input  CNT_W  number of operations in the run; sampled on accepted start.
- base_a  input  W  first A operand; sampled on accepted start.
- base_b  input  W  first B operand; sampled on accepted start.
- step_a  input  W  increment applied to A after each completed op; sampled on accepted start.
- step_b  input  W  increment applied to B after each completed op; sampled on accepted start.
- busy  output  1  high in SEND or WAIT.
- done  output  1  high in DONE.
- checksum  output  W  running sum of result data, mod 2^W.
- resp_count  output  CNT_W  number of results received this run.
- operands_bits_A  output  W  operand A to the GCD unit (registered).
- operands_bits_B  output  W  operand B to the GCD unit (registered).
- operands_val  output  1  operand valid.
- operands_rdy  input  1  GCD unit ready for operands.
- result_bits_data  input  W  GCD result.
- result_val  input  1  result valid.
- result_rdy  output  1  block ready to accept a result.

Behaviour:
- Reset (async, any state, including mid-transfer):
  - state goes to IDLE; all outputs go to 0 immediately.
  - Covers operands_val, result_rdy, busy, done, checksum, resp_count, operands_bits_A/B.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE or DONE with start=1 at a clock edge:
  - Load A=base_a, B=base_b, target=num_reqs.
  - Clear checksum and resp_count.
  - If num_reqs==0, go to DONE; otherwise go to SEND. operands_val is high the cycle after start.
- SEND:
  - operands_val=1; A and B held stable until transfer.
  - Transfer occurs when operands_val && operands_rdy at a clock edge; then go to WAIT.
  - operands_val never drops before a transfer.
- WAIT:
  - result_rdy=1 (subject to the optional feature); operands_val=0.
  - Result transfer occurs when result_val && result_rdy at a clock edge:
    - checksum <= checksum + result_bits_data (wraps mod 2^W).
    - resp_count <= resp_count + 1.
    - A <= A + step_a and B <= B + step_b (both wrap mod 2^W).
  - If resp_count+1 == target, go to DONE; otherwise go to SEND.
- Exactly one operation is outstanding; result_rdy is 0 outside WAIT, and operands_val is 0 outside SEND.
- DONE:
  - done=1; checksum and resp_count hold.
  - start restarts the run as from IDLE.
- start in SEND or WAIT is ignored; sampled inputs may change freely during a run.
- num_reqs = 2^CNT_W-1 is legal.

Optional Feature:
- Macro: GCD_CLIENT_STALL_EN, which enables result-side backpressure injection.
- With the macro defined:
  - An internal 4-bit counter, reset to 0, increments every cycle in WAIT.
  - result_rdy = 1 only in WAIT when counter[1:0]==2'b11, i.e. at most one in four WAIT cycles.
  - The counter clears on entry to WAIT.
- Without the macro: result_rdy = 1 throughout WAIT and no counter exists.
- Checksum and count results are identical in both builds.

Test Plan:
- Single op: base_a=27, base_b=15, steps 0, num_reqs=1, start → operands_val high the next cycle with A=27, B=15; done asserts with checksum=3, resp_count=1.
- Three-op sweep: base_a=21, base_b=49, step_a=4, step_b=0, num_reqs=3 → operands (21,49), (25,49), (29,49) in order; checksum=7+1+1=9, resp_count=3.
- Operand backpressure: hold operands_rdy low 5 cycles in SEND → operands_val stays 1 and A/B are unchanged every cycle; exactly one transfer occurs when rdy rises.
- Zero count: num_reqs=0, start → done=1 the next cycle, checksum=0, operands_val never asserted.
- Reset mid-run: assert reset during WAIT of a 4-op run → all outputs 0 without waiting for a clock edge; a new start with base_a=40, base_b=40, num_reqs=1 gives checksum=40.
- Feature build: GCD_CLIENT_STALL_EN defined, repeat the three-op sweep → result_rdy high only on every fourth WAIT cycle; final checksum is still 9.
